riscv_exc_controller: RTL and testbench



---
 rtl/riscv_exc_pkg.sv | 35 +++
 rtl/riscv_exc_controller_prio_enc.sv | 21 ++
 rtl/riscv_exc_controller.sv | 173 +++++++++++++++++
 tb/tb_riscv_exc_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_exc_pkg.sv
// Shared definitions for the exception/interrupt arbiter: cause codes,
// PC-mux vector indices, arbiter state encoding and a cause-packing helper.
package riscv_exc_pkg;

  // 5-bit exception codes placed in mcause[4:0]
  localparam logic [4:0] EXC_CAUSE_ILLEGAL   = 5'd2;
  localparam logic [4:0] EXC_CAUSE_ECALL     = 5'd11;
  localparam logic [4:0] EXC_CAUSE_LOAD_ERR  = 5'd5;
  localparam logic [4:0] EXC_CAUSE_STORE_ERR = 5'd7;

  // Vector indices handed to the PC mux for synchronous exceptions
  localparam logic [4:0] EXC_VEC_ILLEGAL   = 5'h1E;
  localparam logic [4:0] EXC_VEC_ECALL     = 5'h1F;
  localparam logic [4:0] EXC_VEC_LOAD_ERR  = 5'h1C;
  localparam logic [4:0] EXC_VEC_STORE_ERR = 5'h1D;

  // Bit of the 6-bit cause that marks an interrupt (vs. an exception)
  localparam int IRQ_FLAG = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_IRQ  = 2'd1,
    REQ_SYNC = 2'd2
  } exc_state_t;

  // Pack the interrupt flag and a 5-bit code into the CSR cause format
  function automatic logic [5:0] mk_cause(input logic is_irq, input logic [4:0] code);
    logic [5:0] c;
    c           = 6'd0;
    c[4:0]      = code;
    c[IRQ_FLAG] = is_irq;
    return c;
  endfunction

endpackage

// File: rtl/riscv_exc_controller_prio_enc.sv
// Lowest-index-wins priority encoder for the external interrupt lines.
module riscv_irq_prio_enc #(
  parameter int N_IRQ    = 32,
  parameter int IRQ_ID_W = 5
) (
  input  logic [N_IRQ-1:0]    req,
  output logic                valid,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last to write id
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      valid = valid | req[i];
      id    = req[i] ? IRQ_ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/riscv_exc_controller.sv
// Exception/interrupt arbiter between the core controller and the CSR block.
// Prioritises synchronous exceptions over external interrupts, runs the
// req/ack handshake with the controller, and drives the CSR save/restore
// strobes, the 6-bit cause and the PC-mux vector index.
// Build option: RISCV_EXC_IRQ_SYNC_EN inserts a 2-flop synchroniser in front
// of the interrupt register for asynchronous irq sources (irq latency 4
// cycles instead of 2). Synchronous exception timing is unaffected.
module riscv_exc_controller
  import riscv_exc_pkg::*;
#(
  parameter int N_IRQ    = 32,
  parameter int IRQ_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_IRQ-1:0]    irq_i,
  input  logic                irq_enable_i,
  input  logic                id_valid_i,
  input  logic                illegal_insn_i,
  input  logic                ecall_insn_i,
  input  logic                eret_insn_i,
  input  logic                lsu_load_err_i,
  input  logic                lsu_store_err_i,
  input  logic                exc_ack_i,
  input  logic                exc_kill_i,
  output logic                exc_req_o,
  output logic                exc_sync_o,
  output logic [IRQ_ID_W-1:0] exc_vec_o,
  output logic [5:0]          exc_cause_o,
  output logic                save_exc_cause_o,
  output logic                exc_restore_o
);

  exc_state_t          state, state_next;
  logic [N_IRQ-1:0]    irq_q;
  logic [N_IRQ-1:0]    irq_cand;
  logic                irq_valid;
  logic [IRQ_ID_W-1:0] irq_id;
  logic                sync_valid;
  logic [4:0]          sync_code;
  logic [4:0]          sync_vec;
  logic [5:0]          cause, cause_next;
  logic [IRQ_ID_W-1:0] vec, vec_next;

`ifdef RISCV_EXC_IRQ_SYNC_EN
  logic [N_IRQ-1:0] irq_sync1, irq_sync2;

  // Two-flop synchroniser followed by the interrupt sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync1 <= '0;
      irq_sync2 <= '0;
      irq_q     <= '0;
    end else begin
      irq_sync1 <= irq_i;
      irq_sync2 <= irq_sync1;
      irq_q     <= irq_sync2;
    end
  end
`else
  // Single sample register on the interrupt lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_i;
    end
  end
`endif

  assign irq_cand = irq_q & {N_IRQ{irq_enable_i}};

  riscv_irq_prio_enc #(
    .N_IRQ    (N_IRQ),
    .IRQ_ID_W (IRQ_ID_W)
  ) u_prio_enc (
    .req   (irq_cand),
    .valid (irq_valid),
    .id    (irq_id)
  );

  // Fixed-priority selection among the synchronous exception sources
  always_comb begin
    sync_valid = 1'b1;
    sync_code  = 5'd0;
    sync_vec   = 5'd0;
    if (illegal_insn_i && id_valid_i) begin
      sync_code = EXC_CAUSE_ILLEGAL;
      sync_vec  = EXC_VEC_ILLEGAL;
    end else if (ecall_insn_i && id_valid_i) begin
      sync_code = EXC_CAUSE_ECALL;
      sync_vec  = EXC_VEC_ECALL;
    end else if (lsu_load_err_i) begin
      sync_code = EXC_CAUSE_LOAD_ERR;
      sync_vec  = EXC_VEC_LOAD_ERR;
    end else if (lsu_store_err_i) begin
      sync_code = EXC_CAUSE_STORE_ERR;
      sync_vec  = EXC_VEC_STORE_ERR;
    end else begin
      sync_valid = 1'b0;
    end
  end

  // Arbiter next state, cause/vector latching and the save strobe.
  // In REQ_IRQ an ack wins over everything: the controller has already
  // committed to the interrupt, so the held cause is the one to save.
  always_comb begin
    state_next       = state;
    cause_next       = cause;
    vec_next         = vec;
    save_exc_cause_o = 1'b0;
    case (state)
      IDLE: begin
        if (sync_valid) begin
          state_next = REQ_SYNC;
          cause_next = mk_cause(1'b0, sync_code);
          vec_next   = IRQ_ID_W'(sync_vec);
        end else if (irq_valid) begin
          state_next = REQ_IRQ;
          cause_next = mk_cause(1'b1, 5'(irq_id));
          vec_next   = irq_id;
        end else begin
          state_next = IDLE;
        end
      end
      REQ_IRQ: begin
        if (exc_ack_i) begin
          state_next       = IDLE;
          save_exc_cause_o = 1'b1;
        end else if (sync_valid) begin
          state_next = REQ_SYNC;
          cause_next = mk_cause(1'b0, sync_code);
          vec_next   = IRQ_ID_W'(sync_vec);
        end else if (exc_kill_i) begin
          state_next = IDLE;
        end else begin
          state_next = REQ_IRQ;
        end
      end
      REQ_SYNC: begin
        if (exc_ack_i) begin
          state_next       = IDLE;
          save_exc_cause_o = 1'b1;
        end else begin
          state_next = REQ_SYNC;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, cause and vector registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cause <= 6'd0;
      vec   <= '0;
    end else begin
      state <= state_next;
      cause <= cause_next;
      vec   <= vec_next;
    end
  end

  assign exc_req_o     = (state != IDLE);
  assign exc_sync_o    = (state == REQ_SYNC);
  assign exc_cause_o   = cause;
  assign exc_vec_o     = vec;
  assign exc_restore_o = eret_insn_i & id_valid_i & (state == IDLE);

endmodule

// File: tb/tb_riscv_exc_controller.sv
// Self-checking bench for riscv_exc_controller: directed scenarios followed
// by randomized stimulus, all compared against a behavioural model.
module tb_riscv_exc_controller;

  localparam int N_IRQ    = 32;
  localparam int IRQ_ID_W = 5;
`ifdef RISCV_EXC_IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_IRQ-1:0]    irq_i;
  logic                irq_enable_i, id_valid_i, illegal_insn_i, ecall_insn_i;
  logic                eret_insn_i, lsu_load_err_i, lsu_store_err_i;
  logic                exc_ack_i, exc_kill_i;
  logic                exc_req_o, exc_sync_o, save_exc_cause_o, exc_restore_o;
  logic [IRQ_ID_W-1:0] exc_vec_o;
  logic [5:0]          exc_cause_o;

  always #5 clk = ~clk;

  riscv_exc_controller #(.N_IRQ(N_IRQ), .IRQ_ID_W(IRQ_ID_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq_i            (irq_i),
    .irq_enable_i     (irq_enable_i),
    .id_valid_i       (id_valid_i),
    .illegal_insn_i   (illegal_insn_i),
    .ecall_insn_i     (ecall_insn_i),
    .eret_insn_i      (eret_insn_i),
    .lsu_load_err_i   (lsu_load_err_i),
    .lsu_store_err_i  (lsu_store_err_i),
    .exc_ack_i        (exc_ack_i),
    .exc_kill_i       (exc_kill_i),
    .exc_req_o        (exc_req_o),
    .exc_sync_o       (exc_sync_o),
    .exc_vec_o        (exc_vec_o),
    .exc_cause_o      (exc_cause_o),
    .save_exc_cause_o (save_exc_cause_o),
    .exc_restore_o    (exc_restore_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: is a request pending, is it synchronous, what it says
  bit          m_pend;
  bit          m_sync;
  int          m_cause;
  int          m_vec;
  logic [31:0] m_irq_q;
  logic [31:0] m_pipe[$];

  function automatic int lowest_set(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_sync  = 0;
    m_cause = 0;
    m_vec   = 0;
    m_irq_q = '0;
    m_pipe.delete();
    for (int i = 0; i < IRQ_LAT - 1; i++) m_pipe.push_back(32'd0);
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_clock();
    bit s;
    int code, v, irq;
    s = 1;
    code = 0;
    v = 0;
    if (illegal_insn_i && id_valid_i)      begin code = 2;  v = 30; end
    else if (ecall_insn_i && id_valid_i)   begin code = 11; v = 31; end
    else if (lsu_load_err_i)               begin code = 5;  v = 28; end
    else if (lsu_store_err_i)              begin code = 7;  v = 29; end
    else s = 0;
    irq = irq_enable_i ? lowest_set(m_irq_q) : -1;
    if (!m_pend) begin
      if (s) begin m_pend = 1; m_sync = 1; m_cause = code; m_vec = v; end
      else if (irq >= 0) begin m_pend = 1; m_sync = 0; m_cause = 32 + irq; m_vec = irq; end
    end else if (m_sync) begin
      if (exc_ack_i) m_pend = 0;
    end else begin
      if (exc_ack_i) m_pend = 0;
      else if (s) begin m_sync = 1; m_cause = code; m_vec = v; end
      else if (exc_kill_i) m_pend = 0;
    end
    m_pipe.push_back(irq_i);
    m_irq_q = m_pipe.pop_front();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".req"},     32'(exc_req_o),        32'(m_pend));
    check({tag, ".sync"},    32'(exc_sync_o),       32'(m_pend && m_sync));
    check({tag, ".cause"},   32'(exc_cause_o),      32'(m_cause));
    check({tag, ".vec"},     32'(exc_vec_o),        32'(m_vec));
    check({tag, ".save"},    32'(save_exc_cause_o), 32'(m_pend && exc_ack_i));
    check({tag, ".restore"}, 32'(exc_restore_o),    32'(!m_pend && eret_insn_i && id_valid_i));
  endtask

  // Inputs are set just after a falling edge; check, clock, return at next falling edge
  task automatic cycle(input string tag);
    #2;
    check_model(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    irq_i = '0; irq_enable_i = 1'b0; id_valid_i = 1'b0; illegal_insn_i = 1'b0;
    ecall_insn_i = 1'b0; eret_insn_i = 1'b0; lsu_load_err_i = 1'b0;
    lsu_store_err_i = 1'b0; exc_ack_i = 1'b0; exc_kill_i = 1'b0;
  endtask

  // Quiet inputs and acknowledge until everything in flight has drained
  task automatic drain();
    clear_inputs();
    exc_ack_i = 1'b1;
    repeat (IRQ_LAT + 3) cycle("drain");
    exc_ack_i = 1'b0;
    cycle("drain_idle");
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst.req", 32'(exc_req_o), 32'd0);
    check("rst.cause", 32'(exc_cause_o), 32'd0);
    check("rst.save", 32'(save_exc_cause_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // irq lines 4 and 5, lowest wins
    irq_i = 32'h0000_0030; irq_enable_i = 1'b1;
    repeat (IRQ_LAT + 1) cycle("irq_lat");
    #1;
    check("irq.req", 32'(exc_req_o), 32'd1);
    check("irq.cause", 32'(exc_cause_o), 32'h24);
    check("irq.vec", 32'(exc_vec_o), 32'd4);
    check("irq.sync", 32'(exc_sync_o), 32'd0);
    exc_ack_i = 1'b1; irq_i = '0;
    #1;
    check("irq.save", 32'(save_exc_cause_o), 32'd1);
    cycle("irq_ack");
    exc_ack_i = 1'b0;
    #1;
    check("irq.idle", 32'(exc_req_o), 32'd0);
    check("irq.save_off", 32'(save_exc_cause_o), 32'd0);
    drain();

    // illegal beats ecall; kill ignored while synchronous
    id_valid_i = 1'b1; illegal_insn_i = 1'b1; ecall_insn_i = 1'b1;
    cycle("sync_raise");
    clear_inputs();
    #1;
    check("sync.cause", 32'(exc_cause_o), 32'h02);
    check("sync.vec", 32'(exc_vec_o), 32'h1E);
    check("sync.sync", 32'(exc_sync_o), 32'd1);
    exc_kill_i = 1'b1;
    repeat (2) cycle("sync_kill");
    #1;
    check("sync.kill_ignored", 32'(exc_req_o), 32'd1);
    drain();

    // pending irq 3 pre-empted by a load error
    irq_i = 32'h8; irq_enable_i = 1'b1;
    repeat (IRQ_LAT + 1) cycle("pre_lat");
    irq_i = '0;
    #1;
    check("pre.irq_cause", 32'(exc_cause_o), 32'h23);
    lsu_load_err_i = 1'b1;
    cycle("pre_load");
    lsu_load_err_i = 1'b0;
    #1;
    check("pre.cause", 32'(exc_cause_o), 32'h05);
    check("pre.vec", 32'(exc_vec_o), 32'h1C);
    check("pre.sync", 32'(exc_sync_o), 32'd1);
    exc_ack_i = 1'b1;
    cycle("pre_ack");
    exc_ack_i = 1'b0;
    irq_enable_i = 1'b0;
    #1;
    check("pre.single_strobe", 32'(save_exc_cause_o), 32'd0);
    drain();

    // masked irq, then enable, then kill
    irq_i = 32'h1; irq_enable_i = 1'b0;
    repeat (IRQ_LAT + 3) cycle("mask");
    #1;
    check("mask.req", 32'(exc_req_o), 32'd0);
    irq_enable_i = 1'b1;
    cycle("mask_en");
    #1;
    check("mask.en_req", 32'(exc_req_o), 32'd1);
    exc_kill_i = 1'b1;
    cycle("mask_kill");
    exc_kill_i = 1'b0; irq_enable_i = 1'b0;
    #1;
    check("mask.killed", 32'(exc_req_o), 32'd0);
    drain();

    // eret restore in IDLE vs during a pending irq
    eret_insn_i = 1'b1; id_valid_i = 1'b1;
    #1;
    check("eret.idle", 32'(exc_restore_o), 32'd1);
    cycle("eret_idle");
    clear_inputs();
    irq_i = 32'h1; irq_enable_i = 1'b1;
    repeat (IRQ_LAT + 1) cycle("eret_lat");
    eret_insn_i = 1'b1; id_valid_i = 1'b1;
    #1;
    check("eret.pending", 32'(exc_restore_o), 32'd0);
    cycle("eret_pend");
    drain();

    // reset mid-handshake
    id_valid_i = 1'b1; illegal_insn_i = 1'b1;
    cycle("rst_raise");
    clear_inputs();
    exc_ack_i = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid.req", 32'(exc_req_o), 32'd0);
    check("rstmid.save", 32'(save_exc_cause_o), 32'd0);
    check("rstmid.cause", 32'(exc_cause_o), 32'd0);
    exc_ack_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle("rstmid_idle");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      irq_i           = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 31)) | ($urandom & $urandom & $urandom) : 32'd0;
      irq_enable_i    = ($urandom_range(0, 3) != 0);
      id_valid_i      = $urandom_range(0, 1) == 1;
      illegal_insn_i  = ($urandom_range(0, 9) == 0);
      ecall_insn_i    = ($urandom_range(0, 9) == 0);
      eret_insn_i     = ($urandom_range(0, 7) == 0);
      lsu_load_err_i  = ($urandom_range(0, 19) == 0);
      lsu_store_err_i = ($urandom_range(0, 19) == 0);
      exc_ack_i       = ($urandom_range(0, 3) == 0);
      exc_kill_i      = ($urandom_range(0, 5) == 0);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
